// File: rtl/sim_run_ctrl.sv
// Simulation run controller: sequences main/derived resets, gates host work,
// and drains outstanding transactions before signalling the wrapper to finish.
module sim_run_ctrl #(
    parameter int unsigned RESET_CYCLES         = 20,
    parameter int unsigned DERIVED_RESET_CYCLES = 20,
    parameter int unsigned DRAIN_TIMEOUT        = 1024
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        finish_req,
    input  logic        idle_in,
    output logic        dut_rst_n,
    output logic        derived_rst_n,
    output logic        run_en,
    output logic        finish_out,
    output logic        timeout_flag,
    output logic [2:0]  state,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        StHold    = 3'd0,
        StRelMain = 3'd1,
        StRun     = 3'd2,
        StDrain   = 3'd3,
        StDone    = 3'd4
    } state_e;

    // Transitions compare the pre-edge count, so edge N sees count N-1.
    localparam logic [31:0] HoldLast  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] RelLast   = 32'(RESET_CYCLES + DERIVED_RESET_CYCLES - 1);
    localparam logic [31:0] DrainLast = 32'(DRAIN_TIMEOUT);
    localparam logic        SkipRel   = (DERIVED_RESET_CYCLES == 0);

    state_e      state_q, state_d;
    logic        dut_rst_n_q, dut_rst_n_d;
    logic        derived_rst_n_q, derived_rst_n_d;
    logic        run_en_q, run_en_d;
    logic        finish_q, finish_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] drain_q, drain_d;
    logic [31:0] drain_inc;

    assign drain_inc = drain_q + 32'd1;

    always_comb begin
        state_d         = state_q;
        dut_rst_n_d     = dut_rst_n_q;
        derived_rst_n_d = derived_rst_n_q;
        run_en_d        = run_en_q;
        finish_d        = finish_q;
        timeout_d       = timeout_q;
        drain_d         = drain_q;
        cycle_d         = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;

        case (state_q)
            StHold: begin
                if (finish_req) begin
                    state_d  = StDone;
                    finish_d = 1'b1;
                end else if (cycle_q >= HoldLast) begin
                    dut_rst_n_d = 1'b1;
                    if (SkipRel) begin
                        derived_rst_n_d = 1'b1;
                        run_en_d        = 1'b1;
                        state_d         = StRun;
                    end else begin
                        state_d = StRelMain;
                    end
                end
            end
            StRelMain: begin
                if (finish_req) begin
                    state_d  = StDone;
                    finish_d = 1'b1;
                end else if (cycle_q >= RelLast) begin
                    derived_rst_n_d = 1'b1;
                    run_en_d        = 1'b1;
                    state_d         = StRun;
                end
            end
            StRun: begin
                if (finish_req) begin
                    state_d  = StDrain;
                    run_en_d = 1'b0;
                    drain_d  = 32'd0;
                end
            end
            StDrain: begin
                drain_d = drain_inc;
                // idle_in takes priority over the timeout on the same edge
                if (idle_in) begin
                    state_d   = StDone;
                    finish_d  = 1'b1;
                    timeout_d = 1'b0;
                end else if (drain_inc >= DrainLast) begin
                    state_d   = StDone;
                    finish_d  = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            StDone: begin
                run_en_d = 1'b0;
                finish_d = 1'b1;
            end
            default: begin
                state_d         = StHold;
                dut_rst_n_d     = 1'b0;
                derived_rst_n_d = 1'b0;
                run_en_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q         <= StHold;
            dut_rst_n_q     <= 1'b0;
            derived_rst_n_q <= 1'b0;
            run_en_q        <= 1'b0;
            finish_q        <= 1'b0;
            timeout_q       <= 1'b0;
            cycle_q         <= 32'd0;
            drain_q         <= 32'd0;
        end else begin
            state_q         <= state_d;
            dut_rst_n_q     <= dut_rst_n_d;
            derived_rst_n_q <= derived_rst_n_d;
            run_en_q        <= run_en_d;
            finish_q        <= finish_d;
            timeout_q       <= timeout_d;
            cycle_q         <= cycle_d;
            drain_q         <= drain_d;
        end
    end

    assign state         = state_q;
    assign dut_rst_n     = dut_rst_n_q;
    assign derived_rst_n = derived_rst_n_q;
    assign run_en        = run_en_q;
    assign finish_out    = finish_q;
    assign timeout_flag  = timeout_q;
    assign cycle_count   = cycle_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: default timing on one instance, short reset
// with no derived phase and an 8-edge drain timeout on a second instance.
module tb_sim_run_ctrl;

    logic clk;
    logic rst_a, finish_a, idle_a;
    logic rst_b, finish_b, idle_b;

    logic        dut_a, der_a, run_a, fin_a, to_a;
    logic [2:0]  st_a;
    logic [31:0] cnt_a;
    logic        dut_b, der_b, run_b, fin_b, to_b;
    logic [2:0]  st_b;
    logic [31:0] cnt_b;

    int n_checks = 0;
    int n_errors = 0;
    logic b_seen_rel;

    sim_run_ctrl u_dut_a (
        .CLK           (clk),
        .RST_N         (rst_a),
        .finish_req    (finish_a),
        .idle_in       (idle_a),
        .dut_rst_n     (dut_a),
        .derived_rst_n (der_a),
        .run_en        (run_a),
        .finish_out    (fin_a),
        .timeout_flag  (to_a),
        .state         (st_a),
        .cycle_count   (cnt_a)
    );

    sim_run_ctrl #(
        .RESET_CYCLES         (5),
        .DERIVED_RESET_CYCLES (0),
        .DRAIN_TIMEOUT        (8)
    ) u_dut_b (
        .CLK           (clk),
        .RST_N         (rst_b),
        .finish_req    (finish_b),
        .idle_in       (idle_b),
        .dut_rst_n     (dut_b),
        .derived_rst_n (der_b),
        .run_en        (run_b),
        .finish_out    (fin_b),
        .timeout_flag  (to_b),
        .state         (st_b),
        .cycle_count   (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst_b) b_seen_rel = 1'b0;
        else if (st_b == 3'd1) b_seen_rel = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_state"}, 32'(st_a), 32'd0);
        check({tag, "_dut"}, 32'(dut_a), 32'd0);
        check({tag, "_der"}, 32'(der_a), 32'd0);
        check({tag, "_run"}, 32'(run_a), 32'd0);
        check({tag, "_fin"}, 32'(fin_a), 32'd0);
        check({tag, "_to"}, 32'(to_a), 32'd0);
        check({tag, "_cnt"}, cnt_a, 32'd0);
    endtask

    initial begin
        rst_a = 1'b0; finish_a = 1'b0; idle_a = 1'b0;
        rst_b = 1'b0; finish_b = 1'b0; idle_b = 1'b0;
        #2;
        check_a_zero("por");
        tick(2);
        rst_a = 1'b1;

        // Default sequence: main reset at edge 20, derived + run at edge 40
        tick(19);
        check("a_e19_cnt", cnt_a, 32'd19);
        check("a_e19_dut", 32'(dut_a), 32'd0);
        check("a_e19_state", 32'(st_a), 32'd0);
        tick(1);
        check("a_e20_cnt", cnt_a, 32'd20);
        check("a_e20_dut", 32'(dut_a), 32'd1);
        check("a_e20_der", 32'(der_a), 32'd0);
        check("a_e20_state", 32'(st_a), 32'd1);
        tick(19);
        check("a_e39_der", 32'(der_a), 32'd0);
        check("a_e39_run", 32'(run_a), 32'd0);
        tick(1);
        check("a_e40_der", 32'(der_a), 32'd1);
        check("a_e40_run", 32'(run_a), 32'd1);
        check("a_e40_state", 32'(st_a), 32'd2);

        // idle_in ignored in RUN
        idle_a = 1'b1;
        tick(10);
        check("a_idle_run_state", 32'(st_a), 32'd2);
        check("a_idle_run_fin", 32'(fin_a), 32'd0);
        idle_a = 1'b0;

        // finish pulse at edge 100, idle at edge 110
        tick(49);
        finish_a = 1'b1;
        tick(1);
        finish_a = 1'b0;
        check("a_e100_run", 32'(run_a), 32'd0);
        check("a_e100_state", 32'(st_a), 32'd3);
        tick(9);
        check("a_e109_state", 32'(st_a), 32'd3);
        check("a_e109_fin", 32'(fin_a), 32'd0);
        idle_a = 1'b1;
        tick(1);
        idle_a = 1'b0;
        check("a_e110_fin", 32'(fin_a), 32'd1);
        check("a_e110_to", 32'(to_a), 32'd0);
        check("a_e110_state", 32'(st_a), 32'd4);
        tick(5);
        check("a_done_cnt", cnt_a, 32'd115);
        check("a_done_state", 32'(st_a), 32'd4);
        check("a_done_dut", 32'(dut_a), 32'd1);
        check("a_done_der", 32'(der_a), 32'd1);
        check("a_done_run", 32'(run_a), 32'd0);

        // Asynchronous reset in DONE, then full sequence again
        #2 rst_a = 1'b0;
        #1;
        check_a_zero("rst_done");
        rst_a = 1'b1;
        tick(1);
        check("a_re_e1_cnt", cnt_a, 32'd1);
        check("a_re_e1_state", 32'(st_a), 32'd0);
        tick(19);
        check("a_re_e20_dut", 32'(dut_a), 32'd1);
        check("a_re_e20_state", 32'(st_a), 32'd1);
        tick(20);
        check("a_re_e40_state", 32'(st_a), 32'd2);
        check("a_re_e40_run", 32'(run_a), 32'd1);
        check("a_re_e40_fin", 32'(fin_a), 32'd0);

        // finish_req during HOLD at edge 10
        #2 rst_a = 1'b0;
        #1 rst_a = 1'b1;
        tick(9);
        finish_a = 1'b1;
        tick(1);
        finish_a = 1'b0;
        check("a_hold_fin_state", 32'(st_a), 32'd4);
        check("a_hold_fin_fin", 32'(fin_a), 32'd1);
        check("a_hold_fin_dut", 32'(dut_a), 32'd0);
        check("a_hold_fin_to", 32'(to_a), 32'd0);
        tick(20);
        check("a_hold_e30_state", 32'(st_a), 32'd4);
        check("a_hold_e30_dut", 32'(dut_a), 32'd0);
        check("a_hold_e30_der", 32'(der_a), 32'd0);
        check("a_hold_e30_cnt", cnt_a, 32'd30);

        // Instance B: no derived phase, drain timeout 8
        rst_b = 1'b1;
        tick(4);
        check("b_e4_state", 32'(st_b), 32'd0);
        check("b_e4_dut", 32'(dut_b), 32'd0);
        tick(1);
        check("b_e5_dut", 32'(dut_b), 32'd1);
        check("b_e5_der", 32'(der_b), 32'd1);
        check("b_e5_run", 32'(run_b), 32'd1);
        check("b_e5_state", 32'(st_b), 32'd2);
        tick(4);
        finish_b = 1'b1;
        tick(1);
        finish_b = 1'b0;
        check("b_drain_state", 32'(st_b), 32'd3);
        check("b_drain_run", 32'(run_b), 32'd0);
        tick(7);
        check("b_to7_state", 32'(st_b), 32'd3);
        check("b_to7_fin", 32'(fin_b), 32'd0);
        tick(1);
        check("b_to8_state", 32'(st_b), 32'd4);
        check("b_to8_fin", 32'(fin_b), 32'd1);
        check("b_to8_to", 32'(to_b), 32'd1);
        check("b_no_relmain", 32'(b_seen_rel), 32'd0);

        // idle on the timeout edge wins
        rst_b = 1'b0;
        #1;
        check("b_rst_to", 32'(to_b), 32'd0);
        rst_b = 1'b1;
        tick(5);
        check("b_re_state", 32'(st_b), 32'd2);
        finish_b = 1'b1;
        tick(1);
        finish_b = 1'b0;
        tick(7);
        check("b_idle7_state", 32'(st_b), 32'd3);
        idle_b = 1'b1;
        tick(1);
        idle_b = 1'b0;
        check("b_idle8_state", 32'(st_b), 32'd4);
        check("b_idle8_fin", 32'(fin_b), 32'd1);
        check("b_idle8_to", 32'(to_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sim_run_ctrl.md
SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 Parameter RESET_CYCLES, default 20, number of CLK edges dut_rst_n is held asserted after RST_N release; SHALL be >= 1.
REQ-002 Parameter DERIVED_RESET_CYCLES, default 20, additional CLK edges derived_rst_n is held after dut_rst_n release; 0 SHALL be legal.
REQ-003 Parameter DRAIN_TIMEOUT, default 1024, max CLK edges spent in DRAIN waiting for idle_in; SHALL be >= 1.
REQ-004 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 finish_req  input  1  level request from host poll to end simulation.
REQ-007 idle_in  input  1  DUT reports no outstanding transactions.
REQ-008 dut_rst_n  output  1  active-low reset to main-domain DUT logic.
REQ-009 derived_rst_n  output  1  active-low reset request for derived-clock domain (synchronised by the consumer).
REQ-010 run_en  output  1  DUT may accept new host work.
REQ-011 finish_out  output  1  sticky; simulation wrapper calls $finish when high.
REQ-012 timeout_flag  output  1  sticky; DONE was reached by drain timeout.
REQ-013 state  output  3  encoded FSM state: HOLD=0, REL_MAIN=1, RUN=2, DRAIN=3, DONE=4.
REQ-014 cycle_count  output  32  CLK edges since RST_N release, saturating at 0xFFFFFFFF.

Function
REQ-015 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-016 Edge numbering: first posedge CLK after RST_N deasserts is edge 1; cycle_count SHALL equal N after edge N.
REQ-017 HOLD: dut_rst_n=0, derived_rst_n=0, run_en=0; at edge RESET_CYCLES SHALL move to REL_MAIN and set dut_rst_n=1.
REQ-018 REL_MAIN: dut_rst_n=1, derived_rst_n=0; at edge RESET_CYCLES+DERIVED_RESET_CYCLES SHALL move to RUN setting derived_rst_n=1 and run_en=1 on the same edge.
REQ-019 DERIVED_RESET_CYCLES=0: HOLD SHALL go directly to RUN at edge RESET_CYCLES, both resets and run_en rising together; REL_MAIN never entered.
REQ-020 RUN: on an edge with finish_req=1, SHALL move to DRAIN, clear run_en, clear drain counter.
REQ-021 DRAIN: drain counter increments each edge; on edge with idle_in=1 SHALL move to DONE with finish_out=1, timeout_flag=0.
REQ-022 DRAIN: on the edge where drain counter reaches DRAIN_TIMEOUT with idle_in=0, SHALL move to DONE with finish_out=1, timeout_flag=1.
REQ-023 idle_in=1 on the timeout edge: idle wins, timeout_flag=0.
REQ-024 finish_req=1 in HOLD or REL_MAIN: SHALL move to DONE on that edge, finish_out=1, timeout_flag=0, dut_rst_n/derived_rst_n held at current values thereafter.
REQ-025 finish_req deassertion after being sampled SHALL NOT abort DRAIN or leave DONE.
REQ-026 DONE: terminal until RST_N; run_en=0, finish_out=1; resets keep values held on entry.
REQ-027 cycle_count SHALL keep counting in all states, including DONE, and saturate without wrap.
REQ-028 idle_in SHALL be ignored outside DRAIN.

Reset
REQ-029 RST_N low SHALL immediately force state=HOLD, dut_rst_n=0, derived_rst_n=0, run_en=0, finish_out=0, timeout_flag=0, cycle_count=0, drain counter=0.
REQ-030 RST_N asserted mid-operation (any state, incl. DONE) SHALL restart the full sequence from HOLD on release.

Verification
REQ-031 Defaults, finish_req=0: dut_rst_n rises after edge 20, derived_rst_n and run_en after edge 40, state=2.
REQ-032 DERIVED_RESET_CYCLES=0, RESET_CYCLES=5: both resets and run_en rise after edge 5; state never 1.
REQ-033 RUN, finish_req pulse at edge 100, idle_in rises at edge 110: run_en=0 after edge 100, finish_out=1 after edge 110, timeout_flag=0.
REQ-034 DRAIN_TIMEOUT=8, idle_in=0: finish_out=1 and timeout_flag=1 exactly 8 edges after DRAIN entry; idle_in=1 on that edge instead gives timeout_flag=0.
REQ-035 finish_req=1 at edge 10 (HOLD): DONE after edge 10, dut_rst_n stays 0, finish_out=1.
REQ-036 RST_N pulsed low in DONE: all outputs zero asynchronously; sequence of REQ-031 repeats, cycle_count restarts at 1.
